stereo_frame_scheduler: RTL and testbench
=========================================

// Module: stereo_frame_scheduler
// PURPOSE
// Frame-level sequencer for stereo_match. Grants capture writes into left/right frame BRAMs,
// fires new_frame_in once both frames are complete, blocks capture and readout while matching,
// reopens the SSD BRAM to the display reader on completion. Sits between the camera capture
// path, stereo_match, and the display readout.
// PARAMETERS
// FRAME_CNT_W     16        width of completed-frame counter (wraps)
// DROP_CNT_W      16        width of dropped-capture counter (saturates)
// TIMEOUT_CYCLES  2**24     max MATCH cycles before watchdog abort (only with macro)
// PORTS
// clk_100mhz        in   1            system clock
// sys_rst           in   1            synchronous active-high reset
// left_frame_done   in   1            1-cycle pulse: left capture finished a frame
// right_frame_done  in   1            1-cycle pulse: right capture finished a frame
// match_done        in   1            stereo_match new_frame_out (level, may stay high)
// match_start       out  1            1-cycle pulse to stereo_match new_frame_in
// left_write_en     out  1            capture may write left frame BRAM (gates writing_left)
// right_write_en    out  1            capture may write right frame BRAM (gates writing_right)
// reading_en        out  1            drives stereo_match reading (SSD BRAM to display)
// busy              out  1            high in START and MATCH
// frame_count       out  FRAME_CNT_W  completed matches
// drop_count        out  DROP_CNT_W   capture pulses discarded
// timeout_err       out  1            sticky watchdog error (0 when macro off)
// BEHAVIOUR
// - Reset: state=CAPTURE, latches clear, match_start=0, left/right_write_en=1, reading_en=1,
//   busy=0, counters=0, timeout_err=0, match_done_q=0. Reset mid-MATCH also returns to CAPTURE;
//   stereo_match shares sys_rst.
// - All outputs registered. done_rise = match_done & ~match_done_q (match_done_q updates every cycle).
// - CAPTURE: reading_en=1. left_write_en = ~left_latched, right_write_en = ~right_latched.
//   A done pulse sets its latch; its write_en drops the next cycle, freezing that frame.
//   Simultaneous pulses latch both in the same cycle. Pulse on an already-latched side: drop_count++.
//   Both latched (incl. same-cycle completion) -> START.
// - START (1 cycle): match_start=1, busy=1, write_en=0, reading_en=0, latches clear -> MATCH.
// - MATCH: busy=1, write_en=0, reading_en=0. done_rise -> CAPTURE, frame_count+1 (wrap).
//   The stale high match_done left from the previous frame is not a rise; it is ignored.
// - Latency: latch completes at cycle N -> match_start high at N+1, MATCH from N+2.
//   done_rise at cycle M -> CAPTURE with grants high and frame_count updated at M+1.
// - Drops: any frame_done pulse in START/MATCH, or on a latched side, is counted.
//   Two pulses in one cycle add 2. drop_count saturates at all-ones.
// - Only one match is ever outstanding. Capture is never granted while stereo_match reads the frame BRAMs.
// CONFIGURATION
// STEREO_WATCHDOG_EN defined: a cycle counter clears on MATCH entry and counts in MATCH.
//   On reaching TIMEOUT_CYCLES-1 without done_rise: timeout_err<=1 (sticky until sys_rst).
//   The block then returns to CAPTURE with no frame_count increment; a done_rise on that same cycle takes priority.
// Not defined: no counter logic. MATCH waits indefinitely. timeout_err is tied 0.
// TESTING
// 1 reset, left pulse@10, right pulse@20 -> left_write_en=0@11, match_start=1 only @21, busy@21-..
// 2 both pulses same cycle@5 -> match_start@6; match_done already high from previous frame, rise@40 -> CAPTURE@41, frame_count=1
// 3 3 left pulses + 2 right pulses during MATCH, 1 extra left in CAPTURE after latch -> drop_count=6
// 4 drop_count preset near max (DROP_CNT_W=4): 20 dropped pulses -> drop_count=15, no wrap
// 5 sys_rst asserted mid-MATCH for 1 cycle -> next cycle CAPTURE, grants=1, counters=0, no match_start
// 6 STEREO_WATCHDOG_EN, TIMEOUT_CYCLES=100, no match_done -> timeout_err=1 after 100 MATCH cycles, CAPTURE, frame_count unchanged

Source files
------------

// File: rtl/stereo_frame_scheduler.sv
// Frame-level sequencer for stereo_match: grants capture, launches matching, hands SSD BRAM to display.
// Optional watchdog abort of a stuck match is enabled by defining STEREO_WATCHDOG_EN.
module stereo_frame_scheduler #(
    parameter int unsigned FRAME_CNT_W    = 16,
    parameter int unsigned DROP_CNT_W     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2**24
) (
    input  logic                   clk_100mhz,
    input  logic                   sys_rst,
    input  logic                   left_frame_done,
    input  logic                   right_frame_done,
    input  logic                   match_done,
    output logic                   match_start,
    output logic                   left_write_en,
    output logic                   right_write_en,
    output logic                   reading_en,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic [DROP_CNT_W-1:0]  drop_count,
    output logic                   timeout_err
);

    localparam int unsigned DSUM_W = DROP_CNT_W + 1;

    typedef enum logic [1:0] {CAPTURE, START, MATCH} state_t;

    state_t                  state;
    logic                    left_latched;
    logic                    right_latched;
    logic                    match_done_q;
    logic                    done_rise;
    logic                    left_next;
    logic                    right_next;
    logic [1:0]              drop_inc;
    logic [DSUM_W-1:0]       drop_sum;
    logic [DROP_CNT_W-1:0]   drop_next;

`ifdef STEREO_WATCHDOG_EN
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WD_W-1:0] wd_cnt;
`endif

    // Edge detect, latch update and saturating drop accounting.
    always_comb begin
        done_rise  = match_done & ~match_done_q;
        left_next  = left_latched | left_frame_done;
        right_next = right_latched | right_frame_done;
        drop_inc   = 2'd0;
        if (state == CAPTURE) begin
            drop_inc = 2'(left_frame_done & left_latched) + 2'(right_frame_done & right_latched);
        end else begin
            drop_inc = 2'(left_frame_done) + 2'(right_frame_done);
        end
        drop_sum  = DSUM_W'(drop_count) + DSUM_W'(drop_inc);
        drop_next = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    end

    always_ff @(posedge clk_100mhz) begin
        if (sys_rst) begin
            state          <= CAPTURE;
            left_latched   <= 1'b0;
            right_latched  <= 1'b0;
            match_done_q   <= 1'b0;
            match_start    <= 1'b0;
            left_write_en  <= 1'b1;
            right_write_en <= 1'b1;
            reading_en     <= 1'b1;
            busy           <= 1'b0;
            frame_count    <= '0;
            drop_count     <= '0;
`ifdef STEREO_WATCHDOG_EN
            wd_cnt         <= '0;
            timeout_err    <= 1'b0;
`endif
        end else begin
            match_done_q <= match_done;
            drop_count   <= drop_next;
            match_start  <= 1'b0;
            case (state)
                CAPTURE: begin
                    if (left_next && right_next) begin
                        state          <= START;
                        match_start    <= 1'b1;
                        busy           <= 1'b1;
                        left_write_en  <= 1'b0;
                        right_write_en <= 1'b0;
                        reading_en     <= 1'b0;
                        left_latched   <= 1'b0;
                        right_latched  <= 1'b0;
                    end else begin
                        left_latched   <= left_next;
                        right_latched  <= right_next;
                        left_write_en  <= ~left_next;
                        right_write_en <= ~right_next;
                    end
                end
                START: begin
                    state <= MATCH;
`ifdef STEREO_WATCHDOG_EN
                    wd_cnt <= '0;
`endif
                end
                MATCH: begin
                    // A fresh rise wins over a watchdog expiry in the same cycle.
                    if (done_rise) begin
                        state          <= CAPTURE;
                        frame_count    <= frame_count + FRAME_CNT_W'(1);
                        left_write_en  <= 1'b1;
                        right_write_en <= 1'b1;
                        reading_en     <= 1'b1;
                        busy           <= 1'b0;
                    end
`ifdef STEREO_WATCHDOG_EN
                    else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        state          <= CAPTURE;
                        timeout_err    <= 1'b1;
                        left_write_en  <= 1'b1;
                        right_write_en <= 1'b1;
                        reading_en     <= 1'b1;
                        busy           <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
`endif
                end
                default: state <= CAPTURE;
            endcase
        end
    end

`ifndef STEREO_WATCHDOG_EN
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_stereo_frame_scheduler.sv
// Randomized + directed bench for stereo_frame_scheduler against a frame-level reference model.
module tb_stereo_frame_scheduler;

    localparam int unsigned FCW  = 16;
    localparam int unsigned DCW  = 4;
    localparam int unsigned TMO  = 100;
    localparam int          DMAX = (1 << DCW) - 1;
`ifdef STEREO_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    localparam int P_CAP = 0;
    localparam int P_STR = 1;
    localparam int P_MAT = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           lf = 1'b0;
    logic           rf = 1'b0;
    logic           md = 1'b0;
    logic           match_start, left_write_en, right_write_en, reading_en, busy, timeout_err;
    logic [FCW-1:0] frame_count;
    logic [DCW-1:0] drop_count;

    int checks = 0;
    int failures = 0;

    // Reference model: what the scheduler is doing at the frame level.
    int m_phase, m_frames, m_drops, m_wait;
    bit m_gotl, m_gotr, m_prev, m_terr;
    logic md_lvl = 1'b0;

    stereo_frame_scheduler #(
        .FRAME_CNT_W(FCW), .DROP_CNT_W(DCW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_100mhz(clk), .sys_rst(rst),
        .left_frame_done(lf), .right_frame_done(rf), .match_done(md),
        .match_start(match_start), .left_write_en(left_write_en),
        .right_write_en(right_write_en), .reading_en(reading_en), .busy(busy),
        .frame_count(frame_count), .drop_count(drop_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic add_drops(input int n);
        m_drops = (m_drops + n > DMAX) ? DMAX : m_drops + n;
    endtask

    task automatic model_step();
        bit rise;
        rise   = md && !m_prev;
        m_prev = md;
        if (rst) begin
            m_phase = P_CAP; m_gotl = 0; m_gotr = 0; m_prev = 0;
            m_frames = 0; m_drops = 0; m_terr = 0; m_wait = 0;
        end else if (m_phase == P_CAP) begin
            add_drops(int'(lf && m_gotl) + int'(rf && m_gotr));
            m_gotl = m_gotl || lf;
            m_gotr = m_gotr || rf;
            if (m_gotl && m_gotr) begin
                m_phase = P_STR; m_gotl = 0; m_gotr = 0;
            end
        end else begin
            add_drops(int'(lf) + int'(rf));
            if (m_phase == P_STR) begin
                m_phase = P_MAT; m_wait = 0;
            end else if (rise) begin
                m_phase = P_CAP; m_frames = (m_frames + 1) % (1 << FCW);
            end else if (WD_ON && m_wait == TMO - 1) begin
                m_phase = P_CAP; m_terr = 1;
            end else begin
                m_wait++;
            end
        end
    endtask

    task automatic compare_all();
        check("match_start", match_start, m_phase == P_STR);
        check("busy", busy, m_phase != P_CAP);
        check("reading_en", reading_en, m_phase == P_CAP);
        check("left_write_en", left_write_en, m_phase == P_CAP && !m_gotl);
        check("right_write_en", right_write_en, m_phase == P_CAP && !m_gotr);
        check("frame_count", frame_count, m_frames);
        check("drop_count", drop_count, m_drops);
        check("timeout_err", timeout_err, m_terr);
    endtask

    task automatic tick(input logic l, input logic r, input logic rs);
        @(negedge clk);
        lf = l; rf = r; rst = rs; md = md_lvl;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        // Reset state
        md_lvl = 1'b0;
        do_reset();
        check("rst_write_en", {left_write_en, right_write_en, reading_en}, 3'b111);
        check("rst_counts", {frame_count, 12'(drop_count)}, 28'd0);

        // Left then right pulse, 10 cycles apart
        repeat (9) tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("t1_left_frozen", left_write_en, 1'b0);
        check("t1_right_open", right_write_en, 1'b1);
        repeat (9) tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        check("t1_start", match_start, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        check("t1_start_pulse", {match_start, busy}, 2'b01);
        md_lvl = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        check("t1_frame", frame_count, 16'd1);

        // Same-cycle completion with stale high match_done
        do_reset();
        tick(1'b1, 1'b1, 1'b0);
        check("t2_start", match_start, 1'b1);
        repeat (30) tick(1'b0, 1'b0, 1'b0);
        check("t2_stale_ignored", busy, 1'b1);
        md_lvl = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        md_lvl = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        check("t2_frame", frame_count, 16'd1);
        check("t2_capture", {busy, reading_en}, 2'b01);

        // Drops: one on a latched side, five during MATCH
        md_lvl = 1'b0;
        do_reset();
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("t3_drops", drop_count, 4'd6);

        // Saturation
        do_reset();
        tick(1'b1, 1'b1, 1'b0);
        repeat (10) tick(1'b1, 1'b1, 1'b0);
        check("t4_saturate", drop_count, 4'd15);

        // Reset mid-MATCH
        tick(1'b0, 1'b0, 1'b1);
        check("t5_grants", {left_write_en, right_write_en, busy}, 3'b110);
        check("t5_drops", drop_count, 4'd0);
        tick(1'b0, 1'b0, 1'b0);
        check("t5_no_start", match_start, 1'b0);

        // Long MATCH without match_done
        do_reset();
        tick(1'b1, 1'b1, 1'b0);
        repeat (105) tick(1'b0, 1'b0, 1'b0);
`ifdef STEREO_WATCHDOG_EN
        check("t6_timeout", {timeout_err, busy}, 2'b10);
`else
        check("t6_waiting", {timeout_err, busy}, 2'b01);
`endif
        check("t6_frames", frame_count, 16'd0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) md_lvl = ~md_lvl;
            tick(logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 7) == 0),
                 logic'($urandom_range(0, 599) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
